// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped write-back data cache:
// controller states, address field positions and the store byte-merge.
package dcache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITEBACK,
    S_REFILL,
    S_FLUSH_SCAN,
    S_FLUSH_WB,
    S_FLUSH_DONE
  } state_t;

  localparam int OFFSET_LSB = 2;
  localparam int INDEX_LSB  = 5;

  localparam logic [1:0] SIZE_WORD   = 2'd0;
  localparam logic [1:0] SIZE_BYTE   = 2'd1;
  localparam logic [1:0] SIZE_HALF   = 2'd2;
  localparam logic [1:0] SIZE_TRIPLE = 2'd3;

  // Big-endian lanes: the n low-order data bytes land at offsets k..k+n-1,
  // most significant first; anything that would spill past offset 3 is dropped.
  function automatic logic [31:0] merge_bytes(input logic [31:0] i_word,
                                              input logic [31:0] i_data,
                                              input logic [1:0]  i_offset,
                                              input logic [1:0]  i_size);
    logic [31:0] res;
    int n;
    int k;
    res = i_word;
    case (i_size)
      SIZE_BYTE:   n = 1;
      SIZE_HALF:   n = 2;
      SIZE_TRIPLE: n = 3;
      default:     n = 4;
    endcase
    for (int j = 0; j < 4; j++) begin
      k = int'(i_offset) + j;
      if (j < n && k < 4) res[(3-k)*8 +: 8] = i_data[(n-1-j)*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Line storage for the cache: valid/dirty bits (reset) and tag/data arrays
// (not reset), with one read port, one write port and a bulk valid clear.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = 5,
  parameter int TAG_BITS   = 22,
  parameter int BLOCK_BITS = 256
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [INDEX_BITS-1:0] i_rdIndex,
  output logic                  o_valid,
  output logic                  o_dirty,
  output logic [TAG_BITS-1:0]   o_tag,
  output logic [BLOCK_BITS-1:0] o_data,
  input  logic                  i_wrEn,
  input  logic [INDEX_BITS-1:0] i_wrIndex,
  input  logic                  i_wrValid,
  input  logic                  i_wrDirty,
  input  logic [TAG_BITS-1:0]   i_wrTag,
  input  logic [BLOCK_BITS-1:0] i_wrData,
  input  logic                  i_clearAll
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]      r_valid;
  logic [LINES-1:0]      r_dirty;
  logic [TAG_BITS-1:0]   r_tag  [LINES];
  logic [BLOCK_BITS-1:0] r_data [LINES];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_clearAll) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_wrEn) begin
      r_valid[i_wrIndex] <= i_wrValid;
      r_dirty[i_wrIndex] <= i_wrDirty;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_wrEn) begin
      r_tag[i_wrIndex]  <= i_wrTag;
      r_data[i_wrIndex] <= i_wrData;
    end
  end

  assign o_valid = r_valid[i_rdIndex];
  assign o_dirty = r_dirty[i_rdIndex];
  assign o_tag   = r_tag[i_rdIndex];
  assign o_data  = r_data[i_rdIndex];

endmodule

// File: rtl/dcache_dm_wb.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage
// and the block memory interface; stalls via data_valid_fDC, supports full flush.
module dcache_dm_wb
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = 5,
  parameter int BLOCK_BITS = 256
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [31:0]           data_address_2DC,
  input  logic                  read_2DC,
  input  logic                  write_2DC,
  input  logic [31:0]           data_write_2DC,
  input  logic [1:0]            data_write_size_2DC,
  input  logic                  flush_2DC,
  output logic [31:0]           data_read_fDC,
  output logic                  data_valid_fDC,
  output logic [31:0]           data_address_2DM,
  output logic [BLOCK_BITS-1:0] block_write_2DM,
  output logic                  dBlkWrite,
  input  logic                  block_write_fDM_valid,
  input  logic [BLOCK_BITS-1:0] block_read_fDM,
  output logic                  dBlkRead,
  input  logic                  block_read_fDM_valid
);

  localparam int TAG_BITS = 32 - INDEX_BITS - INDEX_LSB;

  state_t                r_state;
  logic [INDEX_BITS-1:0] r_scanIdx;

  logic [2:0]            w_wordSel;
  logic [INDEX_BITS-1:0] w_reqIndex;
  logic [TAG_BITS-1:0]   w_reqTag;
  logic [INDEX_BITS-1:0] w_rdIndex;
  logic                  w_lineValid;
  logic                  w_lineDirty;
  logic [TAG_BITS-1:0]   w_lineTag;
  logic [BLOCK_BITS-1:0] w_lineData;
  logic [31:0]           w_lineWord;
  logic                  w_hit;
  logic                  w_idle;
  logic                  w_wbActive;
  logic                  w_wrEn;
  logic                  w_wrValid;
  logic                  w_wrDirty;
  logic [TAG_BITS-1:0]   w_wrTag;
  logic [BLOCK_BITS-1:0] w_wrData;
  logic                  w_clearAll;

  assign w_wordSel  = data_address_2DC[INDEX_LSB-1:OFFSET_LSB];
  assign w_reqIndex = data_address_2DC[INDEX_LSB+INDEX_BITS-1:INDEX_LSB];
  assign w_reqTag   = data_address_2DC[31:INDEX_LSB+INDEX_BITS];
  assign w_rdIndex  = (r_state == S_FLUSH_SCAN || r_state == S_FLUSH_WB) ? r_scanIdx : w_reqIndex;
  assign w_lineWord = w_lineData[int'(w_wordSel)*32 +: 32];
  assign w_hit      = w_lineValid && (w_lineTag == w_reqTag);
  assign w_idle     = (r_state == S_IDLE);
  assign w_wbActive = (r_state == S_WRITEBACK) || (r_state == S_FLUSH_WB);

  dcache_line_store #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_BITS  (TAG_BITS),
    .BLOCK_BITS(BLOCK_BITS)
  ) u_store (
    .i_clk     (CLK),
    .i_rst     (RESET),
    .i_rdIndex (w_rdIndex),
    .o_valid   (w_lineValid),
    .o_dirty   (w_lineDirty),
    .o_tag     (w_lineTag),
    .o_data    (w_lineData),
    .i_wrEn    (w_wrEn),
    .i_wrIndex (w_rdIndex),
    .i_wrValid (w_wrValid),
    .i_wrDirty (w_wrDirty),
    .i_wrTag   (w_wrTag),
    .i_wrData  (w_wrData),
    .i_clearAll(w_clearAll)
  );

  // Line updates always target the line currently on the read port.
  always_comb begin
    w_wrEn     = 1'b0;
    w_wrValid  = w_lineValid;
    w_wrDirty  = w_lineDirty;
    w_wrTag    = w_lineTag;
    w_wrData   = w_lineData;
    w_clearAll = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!flush_2DC && write_2DC && w_hit) begin
          w_wrEn    = 1'b1;
          w_wrDirty = 1'b1;
          w_wrData[int'(w_wordSel)*32 +: 32] = merge_bytes(w_lineWord, data_write_2DC,
                                                           data_address_2DC[OFFSET_LSB-1:0],
                                                           data_write_size_2DC);
        end
      end
      S_WRITEBACK: begin
        if (block_write_fDM_valid) begin
          w_wrEn    = 1'b1;
          w_wrDirty = 1'b0;
        end
      end
      S_REFILL: begin
        if (block_read_fDM_valid) begin
          w_wrEn    = 1'b1;
          w_wrValid = 1'b1;
          w_wrDirty = 1'b0;
          w_wrTag   = w_reqTag;
          w_wrData  = block_read_fDM;
        end
      end
      S_FLUSH_SCAN: begin
        if (!(w_lineValid && w_lineDirty)) begin
          w_wrEn     = 1'b1;
          w_wrValid  = 1'b0;
          w_wrDirty  = 1'b0;
          w_clearAll = (r_scanIdx == '1);
        end
      end
      S_FLUSH_WB: begin
        if (block_write_fDM_valid) begin
          w_wrEn    = 1'b1;
          w_wrValid = 1'b0;
          w_wrDirty = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_scanIdx <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (flush_2DC) begin
            r_state   <= S_FLUSH_SCAN;
            r_scanIdx <= '0;
          end else if ((write_2DC || read_2DC) && !w_hit) begin
            r_state <= (w_lineValid && w_lineDirty) ? S_WRITEBACK : S_REFILL;
          end
        end
        S_WRITEBACK:  if (block_write_fDM_valid) r_state <= S_REFILL;
        S_REFILL:     if (block_read_fDM_valid) r_state <= S_IDLE;
        S_FLUSH_SCAN: begin
          if (w_lineValid && w_lineDirty) r_state <= S_FLUSH_WB;
          else if (r_scanIdx == '1)       r_state <= S_FLUSH_DONE;
          else                            r_scanIdx <= r_scanIdx + 1'b1;
        end
        S_FLUSH_WB:   if (block_write_fDM_valid) r_state <= S_FLUSH_SCAN;
        S_FLUSH_DONE: if (!flush_2DC) r_state <= S_IDLE;
        default:      r_state <= S_IDLE;
      endcase
    end
  end

  // A pending miss or flush request holds the pipeline until it resolves.
  assign data_valid_fDC = !RESET && (w_idle ? (!flush_2DC && (!(write_2DC || read_2DC) || w_hit))
                                            : (r_state == S_FLUSH_DONE));
  assign data_read_fDC  = (!RESET && w_idle && !flush_2DC && !write_2DC && read_2DC && w_hit)
                          ? w_lineWord : 32'd0;

  assign dBlkRead         = (r_state == S_REFILL);
  assign dBlkWrite        = w_wbActive;
  assign data_address_2DM = w_wbActive ? {w_lineTag, w_rdIndex, 5'b0}
                          : dBlkRead   ? {w_reqTag, w_reqIndex, 5'b0}
                          : 32'd0;
  assign block_write_2DM  = w_wbActive ? w_lineData : '0;

endmodule

// File: tb/tb_dcache_dm_wb.sv
// Self-checking bench for dcache_dm_wb: a flat architectural memory plus a
// tag/valid/dirty line model predict hits, traffic and load data.
module tb_dcache_dm_wb;

  localparam int IB = 5;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [31:0]  data_address_2DC;
  logic         read_2DC;
  logic         write_2DC;
  logic [31:0]  data_write_2DC;
  logic [1:0]   data_write_size_2DC;
  logic         flush_2DC;
  logic [31:0]  data_read_fDC;
  logic         data_valid_fDC;
  logic [31:0]  data_address_2DM;
  logic [255:0] block_write_2DM;
  logic         dBlkWrite;
  logic         block_write_fDM_valid;
  logic [255:0] block_read_fDM;
  logic         dBlkRead;
  logic         block_read_fDM_valid;

  dcache_dm_wb #(.INDEX_BITS(IB), .BLOCK_BITS(256)) dut (
    .CLK                  (CLK),
    .RESET                (RESET),
    .data_address_2DC     (data_address_2DC),
    .read_2DC             (read_2DC),
    .write_2DC            (write_2DC),
    .data_write_2DC       (data_write_2DC),
    .data_write_size_2DC  (data_write_size_2DC),
    .flush_2DC            (flush_2DC),
    .data_read_fDC        (data_read_fDC),
    .data_valid_fDC       (data_valid_fDC),
    .data_address_2DM     (data_address_2DM),
    .block_write_2DM      (block_write_2DM),
    .dBlkWrite            (dBlkWrite),
    .block_write_fDM_valid(block_write_fDM_valid),
    .block_read_fDM       (block_read_fDM),
    .dBlkRead             (dBlkRead),
    .block_read_fDM_valid (block_read_fDM_valid)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge CLK) cyc++;

  // Backing memory seen by the block interface, and the architectural view.
  logic [31:0] bmem [int unsigned];
  logic [31:0] arch [int unsigned];

  bit          mValid [32];
  bit          mDirty [32];
  logic [21:0] mTag   [32];

  int           lat = 1;
  int           respCnt = 0;
  int           rdHs = 0;
  int           wrHs = 0;
  int           rdHsCyc = 0;
  logic [31:0]  lastRdAddr = '0;
  logic [31:0]  lastWrAddr = '0;
  logic [255:0] lastWrBlk = '0;
  logic [31:0]  wrAddrQ [$];

  function automatic logic [31:0] defWord(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : defWord(a);
  endfunction

  function automatic logic [31:0] archWord(input logic [31:0] a);
    return arch.exists(a) ? arch[a] : defWord(a);
  endfunction

  function automatic logic [255:0] archBlock(input logic [31:0] base);
    logic [255:0] b;
    for (int w = 0; w < 8; w++) b[w*32 +: 32] = archWord(base + 32'(4*w));
    return b;
  endfunction

  // Byte-addressed store into the architectural memory (big-endian words).
  task automatic archStore(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
    int n;
    int k;
    logic [31:0] wa;
    logic [31:0] w;
    n = (size == 2'd0) ? 4 : int'(size);
    wa = {addr[31:2], 2'b00};
    w = archWord(wa);
    for (int j = 0; j < n; j++) begin
      k = int'(addr[1:0]) + j;
      if (k < 4) w[(3-k)*8 +: 8] = data[(n-1-j)*8 +: 8];
    end
    arch[wa] = w;
  endtask

  task automatic clearModel();
    for (int i = 0; i < 32; i++) begin
      mValid[i] = 1'b0;
      mDirty[i] = 1'b0;
      mTag[i]   = '0;
    end
  endtask

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory side: answers a block request after 'lat' cycles of it being held.
  initial begin
    block_read_fDM_valid  = 1'b0;
    block_write_fDM_valid = 1'b0;
    block_read_fDM        = '0;
    forever begin
      @(posedge CLK);
      #2;
      block_read_fDM_valid  = 1'b0;
      block_write_fDM_valid = 1'b0;
      if ((dBlkRead || dBlkWrite) && !RESET) begin
        respCnt++;
        if (respCnt >= lat) begin
          respCnt = 0;
          if (dBlkRead) begin
            for (int w = 0; w < 8; w++)
              block_read_fDM[w*32 +: 32] = memWord(data_address_2DM + 32'(4*w));
            block_read_fDM_valid = 1'b1;
          end else begin
            for (int w = 0; w < 8; w++)
              bmem[data_address_2DM + 32'(4*w)] = block_write_2DM[w*32 +: 32];
            block_write_fDM_valid = 1'b1;
          end
        end
      end else begin
        respCnt = 0;
      end
    end
  end

  // Compare process: bus invariants, writeback contents and load data every cycle.
  always @(negedge CLK) begin
    if (!RESET) begin
      checkOutput("exclusiveReq", 256'(dBlkRead && dBlkWrite), 256'd0);
      checkOutput("addrAlign", 256'(data_address_2DM[4:0]), 256'd0);
      if (!dBlkRead && !dBlkWrite) begin
        checkOutput("idleAddr", 256'(data_address_2DM), 256'd0);
        checkOutput("idleBlk", block_write_2DM, 256'd0);
      end
      if (dBlkWrite && block_write_fDM_valid) begin
        wrHs++;
        lastWrAddr = data_address_2DM;
        lastWrBlk  = block_write_2DM;
        wrAddrQ.push_back(data_address_2DM);
        checkOutput("wbData", block_write_2DM, archBlock(data_address_2DM));
      end
      if (dBlkRead && block_read_fDM_valid) begin
        rdHs++;
        lastRdAddr = data_address_2DM;
        rdHsCyc    = cyc;
      end
      if (data_valid_fDC && read_2DC && !write_2DC && !flush_2DC)
        checkOutput("loadData", 256'(data_read_fDC), 256'(archWord({data_address_2DC[31:2], 2'b00})));
    end
  end

  // One request from issue to completion; entered just after a rising edge.
  task automatic applyStimulus(input bit isWrite, input logic [31:0] addr, input logic [31:0] data,
                               input logic [1:0] size, output int stall, output logic [31:0] rdata,
                               output int doneCyc);
    logic [4:0]  idx;
    logic [21:0] tag;
    bit          expHit;
    bit          expWb;
    logic [31:0] victim;
    int          rd0;
    int          wr0;
    bit          first;
    idx    = addr[9:5];
    tag    = addr[31:10];
    expHit = mValid[idx] && (mTag[idx] == tag);
    expWb  = !expHit && mValid[idx] && mDirty[idx];
    victim = {mTag[idx], idx, 5'b0};
    rd0    = rdHs;
    wr0    = wrHs;
    data_address_2DC    = addr;
    data_write_2DC      = data;
    data_write_size_2DC = size;
    write_2DC           = isWrite;
    read_2DC            = !isWrite;
    first = 1'b1;
    stall = 0;
    forever begin
      @(negedge CLK);
      if (first) begin
        checkOutput("firstCycleValid", 256'(data_valid_fDC), 256'(expHit));
        first = 1'b0;
      end
      if (data_valid_fDC) break;
      stall++;
      if (stall >= 100) begin
        checkOutput("reqDone", 256'(data_valid_fDC), 256'd1);
        break;
      end
    end
    rdata   = data_read_fDC;
    doneCyc = cyc;
    @(posedge CLK);
    #1;
    read_2DC  = 1'b0;
    write_2DC = 1'b0;
    checkOutput("reqReads", 256'(rdHs - rd0), expHit ? 256'd0 : 256'd1);
    checkOutput("reqWrites", 256'(wrHs - wr0), 256'(expWb));
    if (expWb) checkOutput("victimAddr", 256'(lastWrAddr), 256'(victim));
    if (!expHit) checkOutput("refillAddr", 256'(lastRdAddr), 256'({addr[31:5], 5'b0}));
    if (isWrite) archStore(addr, data, size);
    mValid[idx] = 1'b1;
    mTag[idx]   = tag;
    mDirty[idx] = mDirty[idx] && expHit || isWrite;
  endtask

  task automatic flushAll();
    logic [31:0] expQ [$];
    int wr0;
    int n;
    for (int i = 0; i < 32; i++)
      if (mValid[i] && mDirty[i]) expQ.push_back({mTag[i], 5'(i), 5'b0});
    wrAddrQ.delete();
    wr0 = wrHs;
    flush_2DC = 1'b1;
    @(negedge CLK);
    checkOutput("flushFirstValid", 256'(data_valid_fDC), 256'd0);
    n = 0;
    while (!data_valid_fDC && n < 300) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("flushDoneReached", 256'(data_valid_fDC), 256'd1);
    checkOutput("flushWbCount", 256'(wrHs - wr0), 256'(expQ.size()));
    checkOutput("flushWbCountLit", 256'(wrHs - wr0), 256'd2);
    for (int i = 0; i < expQ.size() && i < wrAddrQ.size(); i++)
      checkOutput("flushWbOrder", 256'(wrAddrQ[i]), 256'(expQ[i]));
    if (wrAddrQ.size() >= 2) begin
      checkOutput("flushWbFirstLit", 256'(wrAddrQ[0]), 256'h1440);
      checkOutput("flushWbSecondLit", 256'(wrAddrQ[1]), 256'h23C0);
    end
    repeat (2) begin
      @(negedge CLK);
      checkOutput("flushDoneHold", 256'(data_valid_fDC), 256'd1);
    end
    @(posedge CLK);
    #1;
    flush_2DC = 1'b0;
    @(negedge CLK);
    checkOutput("flushReleaseIdle", 256'(data_valid_fDC), 256'd1);
    @(posedge CLK);
    #1;
    clearModel();
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          stall;
    int          doneCyc;
    int          n;
    int          rd0;
    logic [31:0] rdata;
    RESET               = 1'b1;
    data_address_2DC    = '0;
    read_2DC            = 1'b0;
    write_2DC           = 1'b0;
    data_write_2DC      = '0;
    data_write_size_2DC = '0;
    flush_2DC           = 1'b0;
    bmem[32'h1044] = 32'hDEADBEEF;
    bmem[32'h1444] = 32'h11223344;
    arch = bmem;
    clearModel();

    #3;
    checkOutput("resetValid", 256'(data_valid_fDC), 256'd0);
    checkOutput("resetRead", 256'(dBlkRead), 256'd0);
    checkOutput("resetWrite", 256'(dBlkWrite), 256'd0);
    checkOutput("resetAddr", 256'(data_address_2DM), 256'd0);
    checkOutput("resetData", 256'(data_read_fDC), 256'd0);
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    checkOutput("idleValid", 256'(data_valid_fDC), 256'd1);
    @(posedge CLK);
    #1;

    // Cold miss, then repeat hit.
    applyStimulus(1'b0, 32'h1044, 32'h0, 2'd0, stall, rdata, doneCyc);
    checkOutput("coldData", 256'(rdata), 256'hDEADBEEF);
    checkOutput("coldRefillAddr", 256'(lastRdAddr), 256'h1040);
    checkOutput("coldLatency", 256'(doneCyc - rdHsCyc), 256'd1);
    applyStimulus(1'b0, 32'h1044, 32'h0, 2'd0, stall, rdata, doneCyc);
    checkOutput("hitStall", 256'(stall), 256'd0);

    // Byte store hit, then read back the merged word.
    applyStimulus(1'b1, 32'h1045, 32'hAB, 2'd1, stall, rdata, doneCyc);
    checkOutput("storeHitStall", 256'(stall), 256'd0);
    applyStimulus(1'b0, 32'h1044, 32'h0, 2'd0, stall, rdata, doneCyc);
    checkOutput("byteMerge", 256'(rdata), 256'hDEABBEEF);

    // Conflict miss on a dirty line.
    applyStimulus(1'b0, 32'h1444, 32'h0, 2'd0, stall, rdata, doneCyc);
    checkOutput("dirtyWbAddr", 256'(lastWrAddr), 256'h1040);
    checkOutput("dirtyWbWord1", 256'(lastWrBlk[63:32]), 256'hDEABBEEF);
    checkOutput("dirtyRefillAddr", 256'(lastRdAddr), 256'h1440);
    checkOutput("dirtyStall", 256'(stall >= 2), 256'd1);
    checkOutput("conflictData", 256'(rdata), 256'h11223344);

    // Half, triple (with dropped byte) and full-word stores.
    applyStimulus(1'b1, 32'h1446, 32'h5566, 2'd2, stall, rdata, doneCyc);
    applyStimulus(1'b0, 32'h1444, 32'h0, 2'd0, stall, rdata, doneCyc);
    checkOutput("halfMerge", 256'(rdata), 256'h11225566);
    applyStimulus(1'b1, 32'h1446, 32'hAABBCC, 2'd3, stall, rdata, doneCyc);
    applyStimulus(1'b0, 32'h1444, 32'h0, 2'd0, stall, rdata, doneCyc);
    checkOutput("tripleMerge", 256'(rdata), 256'h1122AABB);
    applyStimulus(1'b1, 32'h1444, 32'hCAFEF00D, 2'd0, stall, rdata, doneCyc);
    applyStimulus(1'b0, 32'h1444, 32'h0, 2'd0, stall, rdata, doneCyc);
    checkOutput("wordStore", 256'(rdata), 256'hCAFEF00D);

    // Store miss that allocates index 30, then flush both dirty lines.
    applyStimulus(1'b1, 32'h23C4, 32'h12345678, 2'd0, stall, rdata, doneCyc);
    checkOutput("storeMissStall", 256'(stall > 0), 256'd1);
    flushAll();
    applyStimulus(1'b0, 32'h1444, 32'h0, 2'd0, stall, rdata, doneCyc);
    checkOutput("postFlushMiss", 256'(stall > 0), 256'd1);
    checkOutput("postFlushData", 256'(rdata), 256'hCAFEF00D);
    applyStimulus(1'b0, 32'h23C4, 32'h0, 2'd0, stall, rdata, doneCyc);
    checkOutput("postFlushData30", 256'(rdata), 256'h12345678);

    // Reset asserted while a refill is outstanding.
    lat = 6;
    rd0 = rdHs;
    data_address_2DC = 32'h2044;
    read_2DC = 1'b1;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!dBlkRead && n < 20);
    checkOutput("refillSeen", 256'(dBlkRead), 256'd1);
    #2;
    RESET = 1'b1;
    #1;
    checkOutput("asyncRead", 256'(dBlkRead), 256'd0);
    checkOutput("asyncWrite", 256'(dBlkWrite), 256'd0);
    checkOutput("asyncAddr", 256'(data_address_2DM), 256'd0);
    checkOutput("asyncValid", 256'(data_valid_fDC), 256'd0);
    checkOutput("asyncBlk", block_write_2DM, 256'd0);
    checkOutput("abandonedRefill", 256'(rdHs - rd0), 256'd0);
    read_2DC = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    lat = 1;
    clearModel();
    arch = bmem;
    @(posedge CLK);
    #1;
    applyStimulus(1'b0, 32'h2044, 32'h0, 2'd0, stall, rdata, doneCyc);
    checkOutput("postResetMiss", 256'(stall > 0), 256'd1);
    checkOutput("postResetRefill", 256'(lastRdAddr), 256'h2040);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dcache_dm_wb.md
Name: dcache_dm_wb

Overview:
- Parametrised direct-mapped, write-back, write-allocate data cache.
- Sits between MEM stage (`*_2DC` / `*_fDC` side) and data memory block interface (`*_2DM` / `*_fDM` side).
- Replaces the current pass-through wiring, which holds `dBlkRead`/`dBlkWrite` low and `data_valid_fDC` high.
- Stalls the pipeline through `data_valid_fDC`; supports a full flush/invalidate for `SYS`.

Parameters:
- INDEX_BITS, 5, log2 of line count (32 lines); legal range 1..10.
- BLOCK_BITS, 256, line size in bits; fixed to the memory block width, 8 words.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  reset, asynchronous, active-high.
- data_address_2DC  in  32  byte address from MEM.
- read_2DC  in  1  load request.
- write_2DC  in  1  store request.
- data_write_2DC  in  32  store data, right-aligned.
- data_write_size_2DC  in  2  bytes to store: 1/2/3, 0 = 4.
- flush_2DC  in  1  level request: write back all dirty lines and invalidate all lines.
- data_read_fDC  out  32  load data, full aligned word.
- data_valid_fDC  out  1  request complete this cycle; when low, the pipeline must hold the request stable.
- data_address_2DM  out  32  block-aligned address (bits [4:0] = 0) for block transfers.
- block_write_2DM  out  256  victim line data.
- dBlkWrite  out  1  block write request.
- block_write_fDM_valid  in  1  block write accepted.
- block_read_fDM  in  256  refill data.
- dBlkRead  out  1  block read request.
- block_read_fDM_valid  in  1  refill data valid.

Behaviour:
- Address fields:
  - byte offset = [1:0]
  - word offset = [4:2]
  - index = [INDEX_BITS+4:5]
  - tag = [31:INDEX_BITS+5]
- Per line storage: valid, dirty, tag, 256-bit data.
- Word w occupies line bits [32w+31:32w]. Byte lane is big-endian: byte offset k maps to word bits [31-8k:24-8k].
- Store merge: the n low-order bytes of `data_write_2DC` go to byte offsets k..k+n-1. Bytes past offset 3 are dropped; no cross-word stores.
- Hit = valid & tag match.
- FSM states: IDLE, WRITEBACK, REFILL, FLUSH_SCAN, FLUSH_WB, FLUSH_DONE.
- IDLE, priority order: `flush_2DC` > `write_2DC` > `read_2DC`.
  - No request: `data_valid_fDC`=1.
  - Read hit: `data_read_fDC` = addressed word, combinational; `data_valid_fDC`=1 the same cycle (zero-wait).
  - Write hit: `data_valid_fDC`=1 combinational; merge bytes and set dirty at the clock edge.
  - Miss with victim valid & dirty: `data_valid_fDC`=0, go to WRITEBACK.
  - Miss otherwise: `data_valid_fDC`=0, go to REFILL.
  - flush asserted: go to FLUSH_SCAN with scan index 0.
- WRITEBACK:
  - Drives `dBlkWrite`=1, `data_address_2DM` = {victim tag, index, 5'b0}, `block_write_2DM` = victim data.
  - Holds until `block_write_fDM_valid`, then clears dirty and goes to REFILL.
- REFILL:
  - Drives `dBlkRead`=1, `data_address_2DM` = {req tag, index, 5'b0}.
  - On `block_read_fDM_valid`: install line (valid=1, dirty=0, new tag), return to IDLE.
  - The request re-evaluates as a hit on the next cycle. Minimum miss penalty is 1 cycle clean, 2 cycles dirty.
- FLUSH_SCAN: for each index 0..2^INDEX_BITS-1 in order:
  - dirty line: go to FLUSH_WB, which uses the WRITEBACK handshake and then returns to the scan.
  - clean line: clear valid, advance one index per cycle.
  - After the last index, go to FLUSH_DONE.
- FLUSH_DONE: `data_valid_fDC`=1 while `flush_2DC` is high; go to IDLE when `flush_2DC` drops.
- In every state other than IDLE and FLUSH_DONE, `data_valid_fDC`=0.
- `dBlkRead`/`dBlkWrite` are never both high. Both are registered-state decodes, glitch-free per state.
- `data_address_2DM` = 0 and `block_write_2DM` = 0 when no transfer is active.
- Request inputs are sampled only in IDLE; changes while stalled are a protocol violation and their effect is undefined.
- Reset (async, any state, including mid-transfer):
  - all valid/dirty bits cleared, FSM to IDLE, scan index 0.
  - `dBlkRead`=`dBlkWrite`=0, `data_address_2DM`=0, `block_write_2DM`=0, `data_read_fDC`=0, `data_valid_fDC`=0 while RESET is high.
  - Any in-flight memory transfer is abandoned.
  - Tag/data arrays need not be reset.

Decomposition:
- Shared package `dcache_pkg`:
  - FSM state enum.
  - Field-position constants (OFFSET_LSB=2, INDEX_LSB=5).
  - Write-size encoding constants.
  - A byte-merge function (word, data, offset, size → word).
- One natural sub-module: `dcache_line_store`, holding the valid/dirty/tag/data arrays with one read port, one write port and a bulk valid-clear.

Test Plan:
- Cold read 0x0000_1044 after reset, memory replies with word1 = 0xDEADBEEF → `dBlkRead` with `data_address_2DM`=0x0000_1040; then `data_read_fDC`=0xDEADBEEF with `data_valid_fDC`=1 one cycle after `block_read_fDM_valid`.
- Repeat read of 0x0000_1044 → `data_valid_fDC`=1 in the same cycle, no `dBlkRead`.
- Store 0xAB, size 1, to 0x0000_1045, then read 0x0000_1044 → 0xDEABBEEF; no memory traffic.
- Read 0x0000_1444 (INDEX_BITS=5, same index as 0x0000_1044, different tag) while the line is dirty → `dBlkWrite` at 0x0000_1040 with word1 = 0xDEABBEEF; then `dBlkRead` at 0x0000_1440; stall for 2+ cycles.
- Dirty lines at indices 2 and 30, then `flush_2DC` held → exactly two `dBlkWrite`s in index order (2, then 30); `data_valid_fDC`=1 only in FLUSH_DONE; every subsequent read misses.
- RESET asserted during REFILL with `dBlkRead` high → `dBlkRead`=0 immediately (asynchronous); after release, the same address misses again.
